sd_cmd_sequencer: RTL and testbench
===================================

Name: sd_cmd_sequencer

Overview:
- Command-issue controller between the register block and the SD CMD engine in the SD host.
- Captures index/argument on a host command write, asserts command-inhibit and pulses new_command to the CMD engine.
- Waits for completion, index error or timeout, then posts maskable interrupt status with write-1-to-clear semantics.
- All logic is in the clk_host domain; cmd_complete/cmd_index_error are already synchronous to clk_host.

Parameters:
- TIMEOUT_CYCLES, 1024, clk_host cycles allowed in WAIT before timeout error (only with SD_CMD_TIMEOUT_EN).
- TMR_W, 11, timeout counter width; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- clk_host  in  1  host clock.
- reset_host  in  1  reset.
- cmd_write  in  1  one-cycle strobe: host wrote the command register.
- cmd_index_in  in  6  command index from the register block.
- cmd_argument_in  in  32  argument from the register block.
- cmd_complete  in  1  completion level from the CMD engine.
- cmd_index_error  in  1  index-error level from the CMD engine, valid with cmd_complete.
- status_clr  in  4  write-1-to-clear strobes for status bits.
- irq_mask  in  4  per-bit interrupt enable.
- new_command  out  1  one-cycle start pulse to the CMD engine.
- cmd_index  out  6  latched index.
- cmd_argument  out  32  latched argument.
- cmd_inhibit  out  1  high while a command is in flight.
- status  out  4  [0] cmd_done, [1] timeout_err, [2] index_err, [3] write_reject.
- irq  out  1  |(status & irq_mask), registered.

Behaviour:
- Clock and reset: one clock, clk_host; reset_host is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; timer 0; edge-detect register 0.
- States:
  - IDLE: on cmd_write, latch index/argument, go to ISSUE.
  - ISSUE: new_command=1 for exactly this one cycle; clear timer; go to WAIT.
  - WAIT: on rising edge of cmd_complete (current & ~previous sample), go to DONE; on timer reaching TIMEOUT_CYCLES-1, go to DONE with timeout flagged.
  - DONE: set status bits; go to IDLE next cycle.
- Latency:
  - cmd_write in cycle N gives new_command high in cycle N+1.
  - cmd_inhibit rises in cycle N+1 (asserted in ISSUE, WAIT, DONE) and deasserts in the cycle after DONE.
- Completion status:
  - Completion edge sets status[0].
  - If cmd_index_error is high on the same sample, status[2] is also set.
  - Timeout sets status[1] only; status[0] is not set.
- Edge detect: the cmd_complete level is sampled every cycle in all states. A level still high from a prior command does not count as completion. A completion edge seen in IDLE/ISSUE is ignored.
- cmd_write while not IDLE: ignored (latched index/argument unchanged); status[3] set.
- Simultaneous completion edge and timeout terminal count: completion wins; status[1] is not set.
- status_clr[i] and a set of bit i in the same cycle: the set wins.
- irq is registered from status & irq_mask, one cycle after status changes.
- cmd_index/cmd_argument hold their value until the next accepted cmd_write.
- Reset mid-operation returns to IDLE immediately. new_command and cmd_inhibit drop asynchronously; no status is posted.

Optional Feature:
- Macro SD_CMD_TIMEOUT_EN.
- Defined: timer instantiated; WAIT times out after TIMEOUT_CYCLES.
- Undefined: no timer; WAIT exits only on a completion edge; status[1] is tied 0; TIMEOUT_CYCLES and TMR_W are unused.

Decomposition:
- Package sd_host_pkg holds:
  - state encoding enum (IDLE, ISSUE, WAIT, DONE);
  - status bit index constants (ST_DONE=0, ST_TOUT=1, ST_IDX=2, ST_REJ=3);
  - CMD index width 6, argument width 32;
  - default TIMEOUT_CYCLES.
- One sub-module: sd_cmd_timer. It is a clearable, enable-gated up-counter with a terminal-count output, instantiated only under SD_CMD_TIMEOUT_EN.

Test Plan:
- Basic command:
  - Stimulus: cmd_write with index 6'd17, argument 32'h0000_0200; cmd_complete raised 5 cycles later.
  - Required: new_command pulses one cycle after cmd_write; cmd_index=17; status=4'b0001; cmd_inhibit low after DONE.
- Index error:
  - Stimulus: cmd_complete and cmd_index_error rise together; irq_mask=4'b0100.
  - Required: status=4'b0101; irq=1 one cycle later; status_clr=4'b0101 then clears both and irq drops.
- Busy reject:
  - Stimulus: second cmd_write with index 6'd24 during WAIT.
  - Required: status[3]=1; cmd_index stays 17; no second new_command pulse.
- Timeout (SD_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stimulus: no completion.
  - Required: DONE 16 cycles after ISSUE; status=4'b0010; a late cmd_complete in IDLE changes nothing.
- Stale level and set-wins:
  - Stimulus: cmd_complete held high across two commands; on the completion edge of a third command, apply status_clr[0] in the same cycle status[0] is set.
  - Required: the second command completes only after a low-then-high edge; status[0] ends 1 on the third command.
- Reset mid-WAIT:
  - Stimulus: assert reset_host mid-WAIT.
  - Required: new_command=0, cmd_inhibit=0, status=0 immediately; next cmd_write is accepted normally.

Source files
------------

// File: rtl/sd_host_pkg.sv
// Shared types and constants for the SD host command path: FSM states,
// status bit positions, command field widths and the default timeout.
package sd_host_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam int ST_DONE = 0;
  localparam int ST_TOUT = 1;
  localparam int ST_IDX  = 2;
  localparam int ST_REJ  = 3;
  localparam int NUM_STATUS = 4;

  localparam int CMD_IDX_W = 6;
  localparam int CMD_ARG_W = 32;

  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_TMR_W = 11;

endpackage

// File: rtl/sd_cmd_timer.sv
// Clearable, enable-gated up-counter with a terminal-count flag, used as
// the WAIT-state watchdog of sd_cmd_sequencer.
module sd_cmd_timer #(
  parameter int TMR_W    = 11,
  parameter int TERMINAL = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == TMR_W'(TERMINAL));

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD host command-issue controller: latches a host command, starts the CMD
// engine, waits for completion and posts W1C status. Optional watchdog: SD_CMD_TIMEOUT_EN.
module sd_cmd_sequencer
  import sd_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TMR_W          = DEF_TMR_W
) (
  input  logic                  clk_host,
  input  logic                  reset_host,
  input  logic                  cmd_write,
  input  logic [CMD_IDX_W-1:0]  cmd_index_in,
  input  logic [CMD_ARG_W-1:0]  cmd_argument_in,
  input  logic                  cmd_complete,
  input  logic                  cmd_index_error,
  input  logic [NUM_STATUS-1:0] status_clr,
  input  logic [NUM_STATUS-1:0] irq_mask,
  output logic                  new_command,
  output logic [CMD_IDX_W-1:0]  cmd_index,
  output logic [CMD_ARG_W-1:0]  cmd_argument,
  output logic                  cmd_inhibit,
  output logic [NUM_STATUS-1:0] status,
  output logic                  irq
);

  state_t                state;
  logic                  complete_q;
  logic                  complete_edge;
  logic                  timeout_hit;
  logic                  done_pend;
  logic                  idx_pend;
  logic                  tout_pend;
  logic [NUM_STATUS-1:0] set_bits;

  assign complete_edge = cmd_complete & ~complete_q;

`ifdef SD_CMD_TIMEOUT_EN
  logic timer_run;
  logic timer_tc;

  // Counting starts in ISSUE so DONE lands exactly TIMEOUT_CYCLES after ISSUE.
  assign timer_run = (state == ISSUE) || (state == WAIT);

  sd_cmd_timer #(
    .TMR_W   (TMR_W),
    .TERMINAL(TIMEOUT_CYCLES - 1)
  ) u_timer (
    .clk     (clk_host),
    .rst     (reset_host),
    .clear   (~timer_run),
    .enable  (timer_run),
    .terminal(timer_tc)
  );

  assign timeout_hit = timer_tc && (state == WAIT);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, TMR_W};
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    set_bits = '0;
    if (cmd_write && (state != IDLE)) begin
      set_bits[ST_REJ] = 1'b1;
    end
    if (state == DONE) begin
      set_bits[ST_DONE] = done_pend;
      set_bits[ST_IDX]  = idx_pend;
      set_bits[ST_TOUT] = tout_pend;
    end
  end

  always_ff @(posedge clk_host or posedge reset_host) begin
    if (reset_host) begin
      state        <= IDLE;
      complete_q   <= 1'b0;
      new_command  <= 1'b0;
      cmd_index    <= '0;
      cmd_argument <= '0;
      cmd_inhibit  <= 1'b0;
      status       <= '0;
      irq          <= 1'b0;
      done_pend    <= 1'b0;
      idx_pend     <= 1'b0;
      tout_pend    <= 1'b0;
    end else begin
      complete_q  <= cmd_complete;
      new_command <= 1'b0;
      irq         <= |(status & irq_mask);
      // Sets take priority over same-cycle write-1-to-clear strobes.
      status      <= (status & ~status_clr) | set_bits;
      case (state)
        IDLE: begin
          if (cmd_write) begin
            cmd_index    <= cmd_index_in;
            cmd_argument <= cmd_argument_in;
            new_command  <= 1'b1;
            cmd_inhibit  <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (complete_edge) begin
            done_pend <= 1'b1;
            idx_pend  <= cmd_index_error;
            tout_pend <= 1'b0;
            state     <= DONE;
          end else if (timeout_hit) begin
            done_pend <= 1'b0;
            idx_pend  <= 1'b0;
            tout_pend <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          cmd_inhibit <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench for sd_cmd_sequencer: a timeline model of command
// acceptance and completion checked every cycle, plus hand-computed spot checks.
module tb_sd_cmd_sequencer;

  localparam int TOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_write = 1'b0;
  logic [5:0]  cmd_index_in = '0;
  logic [31:0] cmd_argument_in = '0;
  logic        cmd_complete = 1'b0;
  logic        cmd_index_error = 1'b0;
  logic [3:0]  status_clr = '0;
  logic [3:0]  irq_mask = '0;
  logic        new_command;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_argument;
  logic        cmd_inhibit;
  logic [3:0]  status;
  logic        irq;

  int compared = 0;
  int mismatched = 0;
  int nc_pulses = 0;
  logic run_checks = 1'b0;

  sd_cmd_sequencer #(
    .TIMEOUT_CYCLES(TOUT),
    .TMR_W         (5)
  ) dut (
    .clk_host       (clk),
    .reset_host     (rst),
    .cmd_write      (cmd_write),
    .cmd_index_in   (cmd_index_in),
    .cmd_argument_in(cmd_argument_in),
    .cmd_complete   (cmd_complete),
    .cmd_index_error(cmd_index_error),
    .status_clr     (status_clr),
    .irq_mask       (irq_mask),
    .new_command    (new_command),
    .cmd_index      (cmd_index),
    .cmd_argument   (cmd_argument),
    .cmd_inhibit    (cmd_inhibit),
    .status         (status),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  // Model: a command accepted in cycle acc is in flight until its DONE cycle end_c.
  int          cyc = 0;
  int          acc = -1;
  int          end_c = -1;
  logic        m_prev = 1'b0;
  logic [3:0]  m_flags = '0;
  logic [3:0]  m_status = '0;
  logic [3:0]  m_sets;
  logic        m_newcmd = 1'b0;
  logic        m_inhibit = 1'b0;
  logic        m_irq = 1'b0;
  logic [5:0]  m_idx = '0;
  logic [31:0] m_arg = '0;
  logic        m_rise;
  logic        m_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; acc = -1; end_c = -1; m_prev = 1'b0; m_flags = '0;
      m_status = '0; m_newcmd = 1'b0; m_inhibit = 1'b0; m_irq = 1'b0;
      m_idx = '0; m_arg = '0;
    end else begin
      m_rise = cmd_complete && !m_prev;
      m_prev = cmd_complete;
      m_sets = '0;
      m_busy = (acc >= 0);
      if (cmd_write) begin
        if (!m_busy) begin
          acc = cyc;
          m_idx = cmd_index_in;
          m_arg = cmd_argument_in;
        end else begin
          m_sets[3] = 1'b1;
        end
      end
      if (m_busy && end_c < 0 && cyc >= acc + 2 && m_rise) begin
        end_c = cyc + 1;
        m_flags = cmd_index_error ? 4'b0101 : 4'b0001;
      end
`ifdef SD_CMD_TIMEOUT_EN
      else if (m_busy && end_c < 0 && cyc == acc + TOUT) begin
        end_c = cyc + 1;
        m_flags = 4'b0010;
      end
`endif
      m_irq = |(m_status & irq_mask);
      if (m_busy && cyc == end_c) begin
        m_sets = m_sets | m_flags;
        acc = -1;
        end_c = -1;
      end
      m_status = (m_status & ~status_clr) | m_sets;
      m_newcmd = (acc == cyc);
      m_inhibit = (acc >= 0);
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_checks) begin
      checkOutput("cyc_new_command", new_command, m_newcmd);
      checkOutput("cyc_cmd_index", cmd_index, m_idx);
      checkOutput("cyc_cmd_argument", cmd_argument, m_arg);
      checkOutput("cyc_cmd_inhibit", cmd_inhibit, m_inhibit);
      checkOutput("cyc_status", status, m_status);
      checkOutput("cyc_irq", irq, m_irq);
      if (new_command === 1'b1) nc_pulses++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic cw, input logic [5:0] idx, input logic [31:0] arg,
                               input logic cc, input logic ie, input logic [3:0] clr);
    cmd_write = cw;
    cmd_index_in = idx;
    cmd_argument_in = arg;
    cmd_complete = cc;
    cmd_index_error = ie;
    status_clr = clr;
    step();
    cmd_write = 1'b0;
    status_clr = '0;
  endtask

  initial begin
    $display("[TB] start");
    #1 rst = 1'b1;
    #1 run_checks = 1'b1;
    checkOutput("reset_status", status, 4'h0);
    checkOutput("reset_new_command", new_command, 1'b0);
    checkOutput("reset_inhibit", cmd_inhibit, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();

    $display("[TB] basic command");
    applyStimulus(1'b1, 6'd17, 32'h0000_0200, 1'b0, 1'b0, 4'h0);
    checkOutput("basic_new_command", new_command, 1'b1);
    checkOutput("model_new_command", m_newcmd, 1'b1);
    checkOutput("basic_cmd_index", cmd_index, 6'd17);
    checkOutput("basic_inhibit", cmd_inhibit, 1'b1);
    step();
    checkOutput("basic_pulse_width", new_command, 1'b0);
    repeat (3) step();
    cmd_complete = 1'b1;
    step();
    checkOutput("basic_inhibit_done", cmd_inhibit, 1'b1);
    step();
    checkOutput("basic_status", status, 4'b0001);
    checkOutput("model_basic_status", m_status, 4'b0001);
    checkOutput("basic_inhibit_low", cmd_inhibit, 1'b0);
    checkOutput("basic_argument", cmd_argument, 32'h0000_0200);
    cmd_complete = 1'b0;
    step();

    $display("[TB] index error and irq");
    irq_mask = 4'b0100;
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 4'b0001);
    checkOutput("idx_pre_clear", status, 4'b0000);
    applyStimulus(1'b1, 6'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'h0);
    step();
    cmd_complete = 1'b1;
    cmd_index_error = 1'b1;
    repeat (2) step();
    checkOutput("idx_status", status, 4'b0101);
    checkOutput("idx_irq_lag", irq, 1'b0);
    step();
    checkOutput("idx_irq", irq, 1'b1);
    checkOutput("model_idx_irq", m_irq, 1'b1);
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b1, 1'b1, 4'b0101);
    checkOutput("idx_cleared", status, 4'b0000);
    step();
    checkOutput("idx_irq_drop", irq, 1'b0);
    cmd_complete = 1'b0;
    cmd_index_error = 1'b0;
    step();

    $display("[TB] busy reject");
    nc_pulses = 0;
    applyStimulus(1'b1, 6'd17, 32'h0000_0200, 1'b0, 1'b0, 4'h0);
    step();
    applyStimulus(1'b1, 6'd24, 32'h0000_1234, 1'b0, 1'b0, 4'h0);
    checkOutput("rej_status", status, 4'b1000);
    checkOutput("rej_cmd_index", cmd_index, 6'd17);
    checkOutput("rej_argument", cmd_argument, 32'h0000_0200);
    cmd_complete = 1'b1;
    repeat (2) step();
    checkOutput("rej_done_status", status, 4'b1001);
    checkOutput("rej_pulse_count", nc_pulses, 1);
    cmd_complete = 1'b0;
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 4'hF);

    $display("[TB] stale level and set-wins");
    applyStimulus(1'b1, 6'd7, 32'h7, 1'b0, 1'b0, 4'h0);
    step();
    cmd_complete = 1'b1;
    repeat (2) step();
    checkOutput("stale_cmd1_status", status, 4'b0001);
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 4'b0001);
    applyStimulus(1'b1, 6'd8, 32'h8, 1'b1, 1'b0, 4'h0);
    repeat (6) step();
    checkOutput("stale_still_busy", cmd_inhibit, 1'b1);
    checkOutput("stale_no_done", status, 4'b0000);
    cmd_complete = 1'b0;
    step();
    cmd_complete = 1'b1;
    repeat (2) step();
    checkOutput("stale_cmd2_status", status, 4'b0001);
    checkOutput("stale_cmd2_inhibit", cmd_inhibit, 1'b0);
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 4'b0001);
    applyStimulus(1'b1, 6'd9, 32'h9, 1'b0, 1'b0, 4'h0);
    step();
    cmd_complete = 1'b1;
    step();
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 4'b0001);
    checkOutput("set_wins_status", status, 4'b0001);
    checkOutput("model_set_wins", m_status, 4'b0001);
    cmd_complete = 1'b0;
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 4'hF);

`ifdef SD_CMD_TIMEOUT_EN
    $display("[TB] timeout");
    applyStimulus(1'b1, 6'd3, 32'h3, 1'b0, 1'b0, 4'h0);
    repeat (16) step();
    checkOutput("tout_inhibit_done", cmd_inhibit, 1'b1);
    step();
    checkOutput("tout_status", status, 4'b0010);
    checkOutput("tout_inhibit_low", cmd_inhibit, 1'b0);
    cmd_complete = 1'b1;
    repeat (2) step();
    checkOutput("tout_late_status", status, 4'b0010);
    checkOutput("tout_late_new_command", new_command, 1'b0);
    cmd_complete = 1'b0;
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 4'hF);
`else
    $display("[TB] no watchdog");
    applyStimulus(1'b1, 6'd3, 32'h3, 1'b0, 1'b0, 4'h0);
    repeat (20) step();
    checkOutput("notout_inhibit", cmd_inhibit, 1'b1);
    checkOutput("notout_status", status, 4'b0000);
    cmd_complete = 1'b1;
    repeat (2) step();
    checkOutput("notout_done", status, 4'b0001);
    cmd_complete = 1'b0;
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 4'hF);
`endif

    $display("[TB] reset mid-WAIT");
    applyStimulus(1'b1, 6'd12, 32'hC, 1'b0, 1'b0, 4'h0);
    step();
    applyStimulus(1'b1, 6'd13, 32'hD, 1'b0, 1'b0, 4'h0);
    checkOutput("rst_pre_status", status, 4'b1000);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_new_command", new_command, 1'b0);
    checkOutput("rst_inhibit", cmd_inhibit, 1'b0);
    checkOutput("rst_status", status, 4'b0000);
    @(posedge clk);
    #3 rst = 1'b0;
    step();
    applyStimulus(1'b1, 6'd9, 32'h99, 1'b0, 1'b0, 4'h0);
    checkOutput("post_rst_new_command", new_command, 1'b1);
    checkOutput("post_rst_cmd_index", cmd_index, 6'd9);
    step();
    cmd_complete = 1'b1;
    repeat (2) step();
    checkOutput("post_rst_status", status, 4'b0001);
    cmd_complete = 1'b0;
    step();

    run_checks = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
